cv32e40p_obi_mem_slave: RTL
===========================

// Module: cv32e40p_obi_mem_slave
// PURPOSE
//  Behavioural OBI memory slave downstream of cv32e40p_core instr_*/data_* ports. Instantiated once per port in the bhv bench.
//  Accepts address phases with configurable grant stalls, then returns in-order responses after a fixed latency.
//  Holds a word-addressed byte-enabled memory array. Supports up to MAX_OUTSTANDING accepted-but-unanswered transactions.
// PARAMETERS
//  MEM_WORDS        65536  memory depth in 32-bit words (power of 2); ADDR_W = $clog2(MEM_WORDS)
//  MAX_OUTSTANDING  2      response FIFO depth (>=1)
//  RVALID_LATENCY   1      cycles from grant to rvalid (>=1)
//  GNT_MODE         0      0=GNT_ALWAYS, 1=GNT_FIXED, 2=GNT_RANDOM (obi_gnt_mode_e)
//  GNT_STALL        0      GNT_FIXED: cycles req_i is held high before gnt_o
//  LFSR_SEED        16'hACE1  GNT_RANDOM: reset value of the 16-bit LFSR (non-zero)
//  INIT_FILE        ""     if non-empty, $readmemh preload of memory at time 0
// PORTS
//  clk_i     in   1   clock; the only clock
//  rst_i     in   1   reset, synchronous, active-high
//  req_i     in   1   OBI address-phase request
//  gnt_o     out  1   OBI grant (combinational on req_i and internal state)
//  addr_i    in   32  byte address
//  we_i      in   1   1=write, 0=read
//  be_i      in   4   byte enables
//  wdata_i   in   32  write data
//  rvalid_o  out  1   OBI response valid, one cycle per transaction
//  rdata_o   out  32  read data; 0 for write responses and when rvalid_o=0
// BEHAVIOUR
//  - Interface: one clock (clk_i). Reset rst_i is synchronous and active-high.
//  - Reset (rst_i=1 at posedge): FIFO emptied, stall counter=0, LFSR=LFSR_SEED. Memory contents retained.
//    While rst_i=1, gnt_o=0, rvalid_o=0 and rdata_o=0.
//  - Reset mid-operation: all outstanding responses are dropped. No rvalid_o follows for them.
//  - Acceptance: transaction accepted at a posedge where req_i & gnt_o. gnt_o = req_i & !full & stall_ok.
//  - stall_ok by mode:
//    GNT_ALWAYS: stall_ok=1.
//    GNT_FIXED: stall_ok = (stall_cnt==GNT_STALL). stall_cnt increments each cycle req_i=1 & !gnt_o. It clears on acceptance or when req_i=0.
//    GNT_RANDOM: stall_ok = lfsr[0]. LFSR uses x^16+x^14+x^13+x^11 and advances every cycle.
//  - Word index = addr_i[ADDR_W+1:2]. addr_i[1:0] and upper bits are ignored; addresses wrap modulo MEM_WORDS.
//  - Write: memory bytes with be_i[k]=1 are updated at the acceptance edge.
//  - Read: the full word is captured into the FIFO entry at the acceptance edge. A read accepted after a write to the same word returns the new data.
//  - FIFO entry = {is_write, rdata[31:0], cnt}, with cnt loaded to RVALID_LATENCY-1 on push.
//    All entry counters decrement in parallel and saturate at 0.
//  - rvalid_o=1 in the cycle the head entry has cnt==0; the head pops at that edge.
//    Later entries never overtake the head, even if their counter is already 0.
//  - Latency: with no stalls, rvalid_o is high exactly RVALID_LATENCY cycles after the acceptance edge.
//    Back-to-back accepts produce back-to-back rvalids.
//  - Full (count==MAX_OUTSTANDING): gnt_o=0, even if the head pops in the same cycle. The grant resumes the cycle after the pop.
//  - Simultaneous push+pop when not full: count unchanged, both actions take effect.
//  - Unrequested grant is never issued: gnt_o=0 whenever req_i=0.
//  - Protocol check: SVA that addr_i/we_i/be_i/wdata_i stay stable while req_i & !gnt_o. Under CV32E40P_ASSERT_ON, a violation calls $error.
// STRUCTURE
//  - Package cv32e40p_obi_slave_pkg:
//    obi_gnt_mode_e {GNT_ALWAYS, GNT_FIXED, GNT_RANDOM};
//    obi_resp_t struct {is_write, rdata, cnt};
//    LFSR tap constant.
//  - Sub-module cv32e40p_obi_resp_fifo: parameterised circular buffer of obi_resp_t with per-entry countdown.
//    Ports: push/entry in, head_ready/pop/head out, full, empty.
//  - Top holds the memory array, grant/stall logic and LFSR.
// TESTING
//  1. Mode 0, latency 1: write 0xDEADBEEF @0x10 be=F at cycle t -> gnt at t, rvalid at t+1; then read 0x10 -> rdata=0xDEADBEEF one cycle after its gnt.
//  2. Preload 0xFFFFFFFF @0x20; write 0x11223344 be=0101 -> read 0x20 returns 0xFF22FF44.
//  3. MAX_OUTSTANDING=2, latency 4, continuous reads: gnt at c0,c1; gnt low c2-c4; rvalid at c4,c5; third gnt at c5.
//  4. GNT_FIXED, GNT_STALL=3: req from c0 -> gnt_o first high at c3; next req gets gnt after 3 more stalled cycles.
//  5. MEM_WORDS=256: write 0xCAFE0001 @0x400 -> read @0x000 returns 0xCAFE0001 (wrap).
//  6. Two reads outstanding, latency 4, rst_i pulsed 1 cycle at c2 -> no rvalid_o afterwards. GNT_RANDOM grant sequence after reset is identical to the sequence from power-up.

Source files
------------

// File: rtl/cv32e40p_obi_slave_pkg.sv
// Shared types for the behavioural OBI memory slave:
// grant modes, response FIFO entry, LFSR taps.
package cv32e40p_obi_slave_pkg;

  typedef enum logic [1:0] {
    GNT_ALWAYS = 2'd0,
    GNT_FIXED  = 2'd1,
    GNT_RANDOM = 2'd2
  } obi_gnt_mode_e;

  localparam int RESP_CNT_W = 8;

  typedef struct packed {
    logic                  is_write;
    logic [31:0]           rdata;
    logic [RESP_CNT_W-1:0] cnt;
  } obi_resp_t;

  // Galois mask for x^16+x^14+x^13+x^11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/cv32e40p_obi_resp_fifo.sv
// In-order response FIFO; every entry counts down
// in parallel, only the head may be released.
module cv32e40p_obi_resp_fifo
  import cv32e40p_obi_slave_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  obi_resp_t entry_i,
  input  logic      pop_i,
  output logic      head_ready_o,
  output obi_resp_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  obi_resp_t        ent_q [DEPTH];
  obi_resp_t        ent_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].cnt != '0) begin
        ent_d[i].cnt = ent_q[i].cnt - RESP_CNT_W'(1);
      end
    end
    if (push_i) begin
      ent_d[wr_q] = entry_i;
    end
    wr_d    = push_i ? inc(wr_q) : wr_q;
    rd_d    = pop_i  ? inc(rd_q) : rd_q;
    count_d = count_q;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    ent_q <= ent_d;
  end

  assign head_o       = ent_q[rd_q];
  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign head_ready_o = !empty_o && (head_o.cnt == '0);

endmodule

// File: rtl/cv32e40p_obi_mem_slave.sv
// Behavioural OBI memory slave with configurable
// grant stalls and fixed-latency in-order responses.
module cv32e40p_obi_mem_slave
  import cv32e40p_obi_slave_pkg::*;
#(
  parameter int          MEM_WORDS       = 65536,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          RVALID_LATENCY  = 1,
  parameter int          GNT_MODE        = 0,
  parameter int          GNT_STALL       = 0,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter              INIT_FILE       = ""
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o
);

  localparam int ADDR_W = $clog2(MEM_WORDS);
  localparam logic [1:0] MODE_BITS = GNT_MODE[1:0];
  localparam obi_gnt_mode_e MODE = obi_gnt_mode_e'(MODE_BITS);

  logic [31:0]       mem_q [MEM_WORDS];
  logic [ADDR_W-1:0] widx;
  logic              full, empty, head_ready;
  logic              stall_ok, accept;
  obi_resp_t         push_entry, head;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;
  logic              unused_sig;

  assign widx = addr_i[ADDR_W+1:2];

  always_comb begin
    stall_ok = 1'b1;
    unique case (1'b1)
      (MODE == GNT_FIXED):
        stall_ok = (stall_cnt_q == 16'(GNT_STALL));
      (MODE == GNT_RANDOM):
        stall_ok = lfsr_q[0];
      default:
        stall_ok = 1'b1;
    endcase
  end

  assign gnt_o  = req_i & ~full & stall_ok & ~rst_i;
  assign accept = gnt_o;

  // Saturate so a full-FIFO stall cannot skip past the grant point
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!req_i || accept) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != 16'(GNT_STALL)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      lfsr_q      <= lfsr_d;
    end
  end

  always @(posedge clk_i) begin
    if (accept && we_i) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) mem_q[widx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  always_comb begin
    push_entry.is_write = we_i;
    push_entry.rdata    = we_i ? 32'h0 : mem_q[widx];
    push_entry.cnt      = RESP_CNT_W'(RVALID_LATENCY - 1);
  end

  cv32e40p_obi_resp_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (accept),
    .entry_i     (push_entry),
    .pop_i       (rvalid_o),
    .head_ready_o(head_ready),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign rvalid_o = head_ready & ~rst_i;
  assign rdata_o  = (rvalid_o && !head.is_write) ? head.rdata : 32'h0;

  assign unused_sig = ^{head.cnt, empty,
                        addr_i[31:ADDR_W+2], addr_i[1:0]};

`ifdef CV32E40P_ASSERT_ON
  a_req_stable: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (req_i && !gnt_o) |=>
      $stable({addr_i, we_i, be_i, wdata_i})
  ) else $error("OBI address phase changed while stalled");
`endif

endmodule
